beat_detector: RTL and testbench
================================

# beat_detector

- Audio-side producer of the one-cycle `beat_trigger` pulse consumed by the animation controller.
- Accumulates mean absolute amplitude over fixed sample windows and tracks a long-term exponential average.
- Fires a beat when window energy exceeds a scaled average, subject to warm-up, hold-off and an `anim_busy` suppression input.
- Sits between the audio sample stream and the animation controller, which drives the blur and zoom filters.

## Interface
Parameters:
- SAMPLE_WIDTH, 16, signed two's-complement audio sample width
- WINDOW_LOG2, 8, window length = 2^WINDOW_LOG2 samples
- AVG_SHIFT, 3, EMA weight = 1/2^AVG_SHIFT; warm-up length = 2^AVG_SHIFT windows
- THRESH_NUM, 3, threshold numerator
- THRESH_SHIFT, 1, threshold denominator = 2^THRESH_SHIFT (defaults give 1.5x)
- HOLDOFF_WINDOWS, 4, evaluated windows forced silent after a beat

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- sample_in  in  SAMPLE_WIDTH  signed audio sample
- sample_in_valid  in  1  sample qualifier; no backpressure, every valid sample accepted
- anim_busy  in  1  animation in progress; suppresses triggering
- beat_trigger  out  1  one-cycle beat pulse
- energy_out  out  SAMPLE_WIDTH  last window mean |x| (unsigned)
- energy_valid  out  1  one-cycle strobe, coincident with any beat_trigger for that window

## Operation
- Magnitude: |x|, with the most negative value saturated to 2^(SAMPLE_WIDTH-1)-1.
- Accumulator: width SAMPLE_WIDTH+WINDOW_LOG2, unsigned; sample counter WINDOW_LOG2 bits, wraps.
- Window close, on the accepting edge of the 2^WINDOW_LOG2-th valid sample:
  - acc+|x| is captured into the eval register.
  - acc and counter are cleared in the same edge; no sample is lost.
- EVAL (one cycle after close):
  - E = captured >> WINDOW_LOG2, then compare using the current average A.
  - Update A <= A + ((E - A) >>> AVG_SHIFT), signed arithmetic with one guard bit, result kept in SAMPLE_WIDTH bits.
- Beat condition: (E << THRESH_SHIFT) > A*THRESH_NUM, computed at full width, no truncation.
- FSM, typedef `beat_state_t`:
  - WARMUP:
    - First window loads A = E directly (no EMA).
    - No triggers.
    - After 2^AVG_SHIFT evaluated windows -> ARMED.
  - ARMED:
    - Beat condition && !anim_busy: pulse beat_trigger, load holdoff = HOLDOFF_WINDOWS -> HOLDOFF.
    - Beat condition && anim_busy: no pulse, stay ARMED, no hold-off.
  - HOLDOFF:
    - Each evaluated window decrements holdoff; no triggers.
    - At 0 -> ARMED; the next window is eligible.
- A updates on every evaluated window in all states, beats included.
- anim_busy is sampled only in the EVAL cycle.
- Reset (any time): all state cleared, partial window discarded, FSM -> WARMUP. Reset values: beat_trigger 0, energy_valid 0, energy_out 0, A 0, acc 0, counter 0.

## Timing
- Latency: last window sample valid in cycle N -> EVAL in cycle N+1 -> beat_trigger, energy_valid and energy_out updated, high during cycle N+2 only.
- beat_trigger is never high for two consecutive cycles.
- Minimum trigger spacing is (HOLDOFF_WINDOWS+1) windows.
- sample_in_valid may be high in every cycle, including EVAL cycles and reset release.
- With WINDOW_LOG2 ≥ 1, EVAL never overlaps the next window close.

## Structure
- Shared package `anim_pkg` holds:
  - `beat_state_t`
  - the localparam width helpers ACC_W = SAMPLE_WIDTH+WINDOW_LOG2 and PROD_W = SAMPLE_WIDTH+THRESH_SHIFT+2
- One sub-module, `window_energy_accum`, covers magnitude, saturation, accumulator, counter and window-close capture strobe.
- The top level holds EVAL, the EMA, the comparator and the FSM.

## Test plan
- Constant |x|=1000 for 16 windows -> energy_out=1000 each window; A=1000 after the first window; no beat_trigger (WARMUP for 8 windows, then 2000 > 3000 false).
- After settle (A=1000), one window at 2000 -> exactly one beat_trigger, high in cycle N+2 of that window's last sample; A becomes 1125.
- Then 5 windows at 3000:
  - First 4 silent (hold-off; A = 1359, 1564, 1743, 1900).
  - Fifth triggers (6000 > 5700).
- anim_busy=1 through a 2000 spike window over A=1000 -> no trigger and no hold-off; busy drops, next 2000 window (A=1125, 4000 > 3375) -> trigger.
- Samples of -32768 -> energy_out=32767; repeated back-to-back windows with sample_in_valid always high -> energy_valid every 256 cycles, no lost samples.
- Assert reset mid-window and mid-HOLDOFF -> outputs 0 immediately; the next beat is possible only after 8 fresh warm-up windows.

Source files
------------

// File: rtl/anim_pkg.sv
// ---------------------------------------------------------------------------
// anim_pkg
// Shared types and width helpers for the audio-to-animation path.
//   beat_state_t : beat detector FSM state encoding
//   ACC_W/PROD_W : accumulator / threshold-product widths at default sizing
//   acc_width()  : SAMPLE_WIDTH + WINDOW_LOG2, for parameterised instances
//   prod_width() : SAMPLE_WIDTH + THRESH_SHIFT + 2, for parameterised instances
// ---------------------------------------------------------------------------
package anim_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } beat_state_t;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_WINDOW_LOG2  = 8;
  localparam int DEF_THRESH_SHIFT = 1;

  localparam int ACC_W  = DEF_SAMPLE_WIDTH + DEF_WINDOW_LOG2;
  localparam int PROD_W = DEF_SAMPLE_WIDTH + DEF_THRESH_SHIFT + 2;

  function automatic int acc_width(input int sample_width, input int window_log2);
    return sample_width + window_log2;
  endfunction

  function automatic int prod_width(input int sample_width, input int thresh_shift);
    return sample_width + thresh_shift + 2;
  endfunction

endpackage

// File: rtl/window_energy_accum.sv
// ---------------------------------------------------------------------------
// window_energy_accum
// Sums |x| over windows of 2^WINDOW_LOG2 valid samples and presents the
// window total together with a one-cycle close strobe.
//   clk            : clock
//   reset          : asynchronous, active-high
//   i_sample       : signed audio sample
//   i_sample_valid : sample qualifier, every valid sample is accepted
//   o_win_close    : high for one cycle after the last sample of a window
//   o_win_sum      : sum of |x| over the window just closed
// ---------------------------------------------------------------------------
module window_energy_accum
  import anim_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WINDOW_LOG2  = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic signed [SAMPLE_WIDTH-1:0]                i_sample,
  input  logic                                          i_sample_valid,
  output logic                                          o_win_close,
  output logic [acc_width(SAMPLE_WIDTH, WINDOW_LOG2)-1:0] o_win_sum
);

  localparam int LP_ACC_W = acc_width(SAMPLE_WIDTH, WINDOW_LOG2);
  localparam logic [SAMPLE_WIDTH-1:0] LP_MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0] LP_MAX_POS  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

  logic [SAMPLE_WIDTH-1:0] w_mag;
  logic [LP_ACC_W-1:0]     w_acc_next;
  logic                    w_last;

  logic [LP_ACC_W-1:0]     r_acc;
  logic [WINDOW_LOG2-1:0]  r_cnt;
  logic                    r_close;
  logic [LP_ACC_W-1:0]     r_sum;

  // The most negative code has no positive twin, so it clamps to full scale.
  always_comb begin
    w_mag = i_sample;
    if (i_sample == LP_MOST_NEG) begin
      w_mag = LP_MAX_POS;
    end else if (i_sample[SAMPLE_WIDTH-1]) begin
      w_mag = -i_sample;
    end
  end

  assign w_acc_next = r_acc + LP_ACC_W'(w_mag);
  assign w_last     = &r_cnt;

  // The closing sample goes straight into the captured sum while the
  // accumulator restarts from zero, so back-to-back windows lose nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_close <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_close <= 1'b0;
      if (i_sample_valid) begin
        r_cnt <= r_cnt + WINDOW_LOG2'(1);
        if (w_last) begin
          r_sum   <= w_acc_next;
          r_acc   <= '0;
          r_close <= 1'b1;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

  assign o_win_close = r_close;
  assign o_win_sum   = r_sum;

endmodule

// File: rtl/beat_detector.sv
// ---------------------------------------------------------------------------
// beat_detector
// Produces a one-cycle beat pulse for the animation controller when the mean
// |x| of a sample window rises above a scaled long-term average.
//   clk             : clock
//   reset           : asynchronous, active-high
//   sample_in       : signed audio sample
//   sample_in_valid : sample qualifier, no backpressure
//   anim_busy       : animation running; a beat seen now is dropped
//   beat_trigger    : one-cycle beat pulse
//   energy_out      : mean |x| of the last window
//   energy_valid    : one-cycle strobe per window, aligned with beat_trigger
//
// state   | meaning
// WARMUP  | average still settling; first window seeds it, no beats
// ARMED   | a window above threshold fires unless anim_busy
// HOLDOFF | counting down evaluated windows after a beat, no beats
// ---------------------------------------------------------------------------
module beat_detector
  import anim_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WINDOW_LOG2     = 8,
  parameter int AVG_SHIFT       = 3,
  parameter int THRESH_NUM      = 3,
  parameter int THRESH_SHIFT    = 1,
  parameter int HOLDOFF_WINDOWS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_in_valid,
  input  logic                           anim_busy,
  output logic                           beat_trigger,
  output logic [SAMPLE_WIDTH-1:0]        energy_out,
  output logic                           energy_valid
);

  localparam int LP_ACC_W  = acc_width(SAMPLE_WIDTH, WINDOW_LOG2);
  localparam int LP_PROD_W = prod_width(SAMPLE_WIDTH, THRESH_SHIFT);
  localparam int LP_WARM_W = AVG_SHIFT + 1;
  localparam logic [LP_WARM_W-1:0] LP_WARM_LAST = LP_WARM_W'((1 << AVG_SHIFT) - 1);
  localparam int LP_HO_W   = $clog2(HOLDOFF_WINDOWS + 2);
  localparam logic [LP_HO_W-1:0] LP_HO_LOAD = LP_HO_W'(HOLDOFF_WINDOWS);

  logic                          w_close;
  logic [LP_ACC_W-1:0]           w_sum;
  logic [SAMPLE_WIDTH-1:0]       w_energy;
  logic [LP_PROD_W-1:0]          w_lhs;
  logic [LP_PROD_W-1:0]          w_rhs;
  logic                          w_beat;
  logic signed [SAMPLE_WIDTH:0]  w_diff;
  logic signed [SAMPLE_WIDTH:0]  w_step;
  logic [SAMPLE_WIDTH-1:0]       w_avg_ema;

  beat_state_t                   r_state;
  logic [SAMPLE_WIDTH-1:0]       r_avg;
  logic [LP_WARM_W-1:0]          r_warm_cnt;
  logic [LP_HO_W-1:0]            r_holdoff;
  logic                          r_beat_trigger;
  logic                          r_energy_valid;
  logic [SAMPLE_WIDTH-1:0]       r_energy_out;

  window_energy_accum #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .WINDOW_LOG2  (WINDOW_LOG2)
  ) u_accum (
    .clk            (clk),
    .reset          (reset),
    .i_sample       (sample_in),
    .i_sample_valid (sample_in_valid),
    .o_win_close    (w_close),
    .o_win_sum      (w_sum)
  );

  assign w_energy = SAMPLE_WIDTH'(w_sum >> WINDOW_LOG2);

  // Both sides widened before scaling so neither the shift nor the product
  // can wrap.
  assign w_lhs  = LP_PROD_W'(w_energy) << THRESH_SHIFT;
  assign w_rhs  = LP_PROD_W'(r_avg) * LP_PROD_W'(THRESH_NUM);
  assign w_beat = (w_lhs > w_rhs);

  // Guard bit keeps E - A signed; the arithmetic shift floors, so the
  // average never steps past E and stays within the unsigned range.
  assign w_diff    = $signed({1'b0, w_energy}) - $signed({1'b0, r_avg});
  assign w_step    = w_diff >>> AVG_SHIFT;
  assign w_avg_ema = SAMPLE_WIDTH'($signed({1'b0, r_avg}) + w_step);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= WARMUP;
      r_avg          <= '0;
      r_warm_cnt     <= LP_WARM_LAST;
      r_holdoff      <= '0;
      r_beat_trigger <= 1'b0;
      r_energy_valid <= 1'b0;
      r_energy_out   <= '0;
    end else begin
      r_beat_trigger <= 1'b0;
      r_energy_valid <= 1'b0;
      if (w_close) begin
        r_energy_valid <= 1'b1;
        r_energy_out   <= w_energy;
        r_avg          <= w_avg_ema;
        case (r_state)
          WARMUP: begin
            if (r_warm_cnt == LP_WARM_LAST) begin
              r_avg <= w_energy;
            end
            if (r_warm_cnt == '0) begin
              r_state <= ARMED;
            end else begin
              r_warm_cnt <= r_warm_cnt - LP_WARM_W'(1);
            end
          end
          ARMED: begin
            // A beat masked by anim_busy is simply lost; no hold-off follows.
            if (w_beat && !anim_busy) begin
              r_beat_trigger <= 1'b1;
              if (HOLDOFF_WINDOWS > 0) begin
                r_holdoff <= LP_HO_LOAD;
                r_state   <= HOLDOFF;
              end
            end
          end
          HOLDOFF: begin
            r_holdoff <= r_holdoff - LP_HO_W'(1);
            if (r_holdoff <= LP_HO_W'(1)) begin
              r_state <= ARMED;
            end
          end
          default: begin
            r_state <= WARMUP;
          end
        endcase
      end
    end
  end

  assign beat_trigger = r_beat_trigger;
  assign energy_valid = r_energy_valid;
  assign energy_out   = r_energy_out;

endmodule

// File: tb/tb_beat_detector.sv
module tb_beat_detector;

  typedef struct {
    int energy;
    int trig;
    int cyc;
  } sb_item_t;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               sample_in_valid;
  logic               anim_busy;
  logic               beat_trigger;
  logic [15:0]        energy_out;
  logic               energy_valid;

  int       n_checks = 0;
  int       n_fails  = 0;
  int       cyc      = 0;
  sb_item_t sb_q[$];
  sb_item_t mon_item;

  beat_detector #(
    .SAMPLE_WIDTH    (16),
    .WINDOW_LOG2     (8),
    .AVG_SHIFT       (3),
    .THRESH_NUM      (3),
    .THRESH_SHIFT    (1),
    .HOLDOFF_WINDOWS (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .anim_busy       (anim_busy),
    .beat_trigger    (beat_trigger),
    .energy_out      (energy_out),
    .energy_valid    (energy_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected window result per energy_valid strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (energy_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_energy_valid: got energy %0d trigger %0d, expected no output (cycle %0d)",
                   energy_out, beat_trigger, cyc);
        end else begin
          mon_item = sb_q.pop_front();
          check("energy_out", int'(energy_out), mon_item.energy);
          check("beat_trigger", int'(beat_trigger), mon_item.trig);
          check("output_cycle", cyc, mon_item.cyc);
        end
      end else begin
        check("trigger_without_window", int'(beat_trigger), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_sample(input int v, input bit neg);
    if (v >= 32768) sample_in = 16'sh8000;
    else if (neg)   sample_in = 16'(-v);
    else            sample_in = 16'(v);
  endtask

  // Even samples carry a, odd samples b; every other pair is negated.
  // Gap cycles present a full-scale value with valid low.
  task automatic send_window(input int a, input int b, input bit gaps,
                             input int exp_e, input int exp_trig);
    sb_item_t it;
    for (int k = 0; k < 256; k++) begin
      if (gaps && (k % 37) == 5) begin
        sample_in_valid = 1'b0;
        sample_in       = 16'sh7fff;
        @(negedge clk);
      end
      drive_sample(((k % 2) == 0) ? a : b, (k % 4) >= 2);
      sample_in_valid = 1'b1;
      if (k == 255) begin
        it.energy = exp_e;
        it.trig   = exp_trig;
        it.cyc    = cyc + 2;
        sb_q.push_back(it);
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    sample_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_pending", sb_q.size(), 0);
  endtask

  // Loud partial window, then asynchronous reset in mid-cycle.
  task automatic partial_and_reset(input int nsamp, input int last_e);
    for (int k = 0; k < nsamp; k++) begin
      drive_sample(30000, k[1]);
      sample_in_valid = 1'b1;
      @(negedge clk);
    end
    check("energy_out_before_reset", int'(energy_out), last_e);
    #2 reset = 1'b1;
    #1;
    check("reset_async_energy_out", int'(energy_out), 0);
    check("reset_async_energy_valid", int'(energy_valid), 0);
    check("reset_async_beat_trigger", int'(beat_trigger), 0);
    sb_q.delete();
    sample_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    sample_in       = '0;
    sample_in_valid = 1'b0;
    anim_busy       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_energy_out", int'(energy_out), 0);
    check("reset_energy_valid", int'(energy_valid), 0);
    check("reset_beat_trigger", int'(beat_trigger), 0);
    reset = 1'b0;

    // Settle on 1000: 8 warm-up windows then 8 armed windows, no beats.
    for (int w = 0; w < 16; w++) send_window(1000, 1000, w[0], 1000, 0);
    // A=1000: 4000 > 3000 fires, A -> 1125.
    send_window(2000, 2000, 1'b0, 2000, 1);
    // Hold-off 4 windows (A 1359,1564,1743,1900), fifth: 6000 > 5700.
    for (int w = 0; w < 5; w++) send_window(3000, 3000, 1'b0, 3000, (w == 4) ? 1 : 0);

    // Reset while in hold-off and mid-window.
    partial_and_reset(100, 3000);

    // Fresh warm-up to A=1000, then busy-masked spike, then real spike.
    for (int w = 0; w < 8; w++) send_window(1000, 1000, 1'b0, 1000, 0);
    anim_busy = 1'b1;
    send_window(1000, 3000, 1'b0, 2000, 0);
    idle(4);
    anim_busy = 1'b0;
    send_window(2000, 2000, 1'b0, 2000, 1);

    // Reset mid-window; the 8th warm-up window is a spike that must not fire.
    partial_and_reset(60, 2000);
    for (int w = 0; w < 7; w++) send_window(1000, 1000, 1'b0, 1000, 0);
    send_window(2000, 2000, 1'b0, 2000, 0);
    send_window(2000, 2000, 1'b0, 2000, 1);

    // Most-negative samples saturate; back-to-back windows, valid always high.
    send_window(32768, 32768, 1'b0, 32767, 0);
    send_window(32768, 32768, 1'b0, 32767, 0);

    idle(4);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
